// File: rtl/fb_pixel_write_arbiter.sv
// Two-requester pixel write arbiter for the SDRAM framebuffer Avalon write port,
// with a full-screen clear fill sequencer.
module fb_pixel_write_arbiter #(
    parameter int                H_RES   = 640,
    parameter int                V_RES   = 480,
    parameter int                COORD_W = 10,
    parameter int                PIX_W   = 16,
    parameter int                ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] FB_BASE = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [COORD_W-1:0] req0_x,
    input  logic [COORD_W-1:0] req0_y,
    input  logic [PIX_W-1:0]   req0_color,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [COORD_W-1:0] req1_x,
    input  logic [COORD_W-1:0] req1_y,
    input  logic [PIX_W-1:0]   req1_color,
    input  logic               clr_start,
    input  logic [PIX_W-1:0]   clr_color,
    output logic               clr_busy,
    output logic [ADDR_W-1:0]  avm_address,
    output logic               avm_write,
    output logic [PIX_W-1:0]   avm_writedata,
    input  logic               avm_waitrequest,
    output logic [15:0]        drop_count
);

    localparam int                NPIX     = H_RES * V_RES;
    localparam int                CNT_W    = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NPIX - 1);
    localparam logic [ADDR_W-1:0] BPP      = ADDR_W'(PIX_W / 8);
    localparam logic [ADDR_W-1:0] H_RES_A  = ADDR_W'(H_RES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_CLEAR
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_last_grant;
    logic               r_clr_pend;
    logic [PIX_W-1:0]   r_clr_color;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  w_addr_nxt;
    logic [PIX_W-1:0]   r_data;
    logic [PIX_W-1:0]   w_data_nxt;
    logic               r_write;
    logic               w_write_nxt;
    logic [15:0]        r_drop;

    logic               w_can_accept;
    logic               w_grant1;
    logic               w_acc;
    logic               w_in_range;
    logic               w_clr_busy;
    logic               w_clr_take;
    logic               w_clr_enter;
    logic [COORD_W-1:0] w_sel_x;
    logic [COORD_W-1:0] w_sel_y;
    logic [PIX_W-1:0]   w_sel_color;
    logic [ADDR_W-1:0]  w_pix_addr;

    assign w_clr_busy   = r_clr_pend || (r_state == S_CLEAR);
    assign w_clr_take   = clr_start && !w_clr_busy;
    // reset_n gates ready so every output reads 0 while reset is held
    assign w_can_accept = reset_n && !r_clr_pend &&
                          ((r_state == S_IDLE) || ((r_state == S_WRITE) && !avm_waitrequest));

    // r_last_grant==1 means req0 wins a tie
    assign w_grant1   = req1_valid && (!req0_valid || !r_last_grant);
    assign req0_ready = w_can_accept && req0_valid && !w_grant1;
    assign req1_ready = w_can_accept && w_grant1;
    assign w_acc      = req0_ready || req1_ready;

    assign w_sel_x     = w_grant1 ? req1_x : req0_x;
    assign w_sel_y     = w_grant1 ? req1_y : req0_y;
    assign w_sel_color = w_grant1 ? req1_color : req0_color;
    assign w_in_range  = (32'(w_sel_x) < H_RES) && (32'(w_sel_y) < V_RES);
    assign w_pix_addr  = FB_BASE + (ADDR_W'(w_sel_y) * H_RES_A + ADDR_W'(w_sel_x)) * BPP;

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_write_nxt = r_write;
        w_cnt_nxt   = r_cnt;
        w_clr_enter = 1'b0;
        case (r_state)
            S_IDLE, S_WRITE: begin
                if ((r_state == S_IDLE) || !avm_waitrequest) begin
                    if (w_acc && w_in_range) begin
                        w_addr_nxt  = w_pix_addr;
                        w_data_nxt  = w_sel_color;
                        w_write_nxt = 1'b1;
                        w_state_nxt = S_WRITE;
                    end else if (!w_acc && r_clr_pend) begin
                        // Fill starts straight from a completing write, no idle gap
                        w_cnt_nxt   = '0;
                        w_addr_nxt  = FB_BASE;
                        w_data_nxt  = r_clr_color;
                        w_write_nxt = 1'b1;
                        w_clr_enter = 1'b1;
                        w_state_nxt = S_CLEAR;
                    end else begin
                        w_write_nxt = 1'b0;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_CLEAR: begin
                if (!avm_waitrequest) begin
                    if (r_cnt == CNT_LAST) begin
                        w_write_nxt = 1'b0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt  = r_cnt + CNT_W'(1);
                        w_addr_nxt = r_addr + BPP;
                    end
                end
            end
            default: begin
                w_write_nxt = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_clr_pend   <= 1'b0;
            r_clr_color  <= '0;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_data       <= '0;
            r_write      <= 1'b0;
            r_drop       <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
            r_write <= w_write_nxt;
            if (w_acc) begin
                r_last_grant <= w_grant1;
            end
            if (w_clr_enter) begin
                r_clr_pend <= 1'b0;
            end else if (w_clr_take) begin
                r_clr_pend <= 1'b1;
            end
            if (w_clr_take) begin
                r_clr_color <= clr_color;
            end
            if (w_acc && !w_in_range && (r_drop != 16'hFFFF)) begin
                r_drop <= r_drop + 16'd1;
            end
        end
    end

    assign clr_busy      = w_clr_busy;
    assign avm_address   = r_addr;
    assign avm_write     = r_write;
    assign avm_writedata = r_data;
    assign drop_count    = r_drop;

endmodule

// File: tb/tb_fb_pixel_write_arbiter.sv
// Bench for fb_pixel_write_arbiter: a 640x480 instance for pixel traffic and a
// 4x2 instance for clear sequencing, checked through a write scoreboard.
module tb_fb_pixel_write_arbiter;

    localparam int CW = 10;
    localparam int PW = 16;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          r0v, r1v;
    logic [CW-1:0] r0x, r0y, r1x, r1y;
    logic [PW-1:0] r0c, r1c;
    logic          clr_start;
    logic [PW-1:0] clr_color;
    logic          waitreq;

    logic          b_r0rdy, b_r1rdy, b_busy, b_wr;
    logic [AW-1:0] b_addr;
    logic [PW-1:0] b_data;
    logic [15:0]   b_drop;
    logic          s_r0rdy, s_r1rdy, s_busy, s_wr;
    logic [AW-1:0] s_addr;
    logic [PW-1:0] s_data;
    logic [15:0]   s_drop;

    always #5 clk = ~clk;

    fb_pixel_write_arbiter #(.H_RES(640), .V_RES(480), .COORD_W(CW), .PIX_W(PW), .ADDR_W(AW), .FB_BASE('0)) u_big (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(r0v), .req0_ready(b_r0rdy), .req0_x(r0x), .req0_y(r0y), .req0_color(r0c),
        .req1_valid(r1v), .req1_ready(b_r1rdy), .req1_x(r1x), .req1_y(r1y), .req1_color(r1c),
        .clr_start(1'b0), .clr_color(clr_color), .clr_busy(b_busy),
        .avm_address(b_addr), .avm_write(b_wr), .avm_writedata(b_data),
        .avm_waitrequest(waitreq), .drop_count(b_drop)
    );

    fb_pixel_write_arbiter #(.H_RES(4), .V_RES(2), .COORD_W(CW), .PIX_W(PW), .ADDR_W(AW), .FB_BASE('0)) u_small (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(r0v), .req0_ready(s_r0rdy), .req0_x(r0x), .req0_y(r0y), .req0_color(r0c),
        .req1_valid(r1v), .req1_ready(s_r1rdy), .req1_x(r1x), .req1_y(r1y), .req1_color(r1c),
        .clr_start(clr_start), .clr_color(clr_color), .clr_busy(s_busy),
        .avm_address(s_addr), .avm_write(s_wr), .avm_writedata(s_data),
        .avm_waitrequest(waitreq), .drop_count(s_drop)
    );

    typedef struct {
        logic          sel;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [PW-1:0] c;
        logic          exp_wr;
        logic [AW-1:0] exp_addr;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [PW-1:0] data;
    } wr_t;

    vec_t   vecs[7];
    wr_t    exp_q[$];
    wr_t    mon_e;
    int     n_chk = 0;
    int     n_fail = 0;
    int     n_pop = 0;
    logic [1:0] mon_sel;

    wire          m_wr   = (mon_sel == 2'd0) ? b_wr   : (mon_sel == 2'd1) ? s_wr : 1'b0;
    wire [AW-1:0] m_addr = (mon_sel == 2'd0) ? b_addr : s_addr;
    wire [PW-1:0] m_data = (mon_sel == 2'd0) ? b_data : s_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every completed Avalon write must match the head of exp_q
    always @(negedge clk) begin
        if (m_wr && !waitreq) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", m_addr, m_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 64'(m_addr), 64'(mon_e.addr));
                check("wr_data", 64'(m_data), 64'(mon_e.data));
            end
            n_pop++;
        end
    end

    task automatic do_reset();
        reset_n   = 1'b0;
        r0v       = 1'b0;
        r1v       = 1'b0;
        clr_start = 1'b0;
        waitreq   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int pop0;
        int exp_drop;
        logic exp0;

        reset_n = 1'b0;
        r0v = 1'b0; r1v = 1'b0;
        r0x = '0; r0y = '0; r1x = '0; r1y = '0; r0c = '0; r1c = '0;
        clr_start = 1'b0; clr_color = '0; waitreq = 1'b0;
        mon_sel = 2'd0;

        vecs[0] = '{1'b0, 10'd3,    10'd2,    16'hF800, 1'b1, 32'h0000_0A06};
        vecs[1] = '{1'b1, 10'd0,    10'd0,    16'h1234, 1'b1, 32'h0000_0000};
        vecs[2] = '{1'b0, 10'd639,  10'd479,  16'hFFFF, 1'b1, 32'h0009_5FFE};
        vecs[3] = '{1'b1, 10'd640,  10'd0,    16'h5555, 1'b0, 32'h0000_0000};
        vecs[4] = '{1'b1, 10'd0,    10'd480,  16'h6666, 1'b0, 32'h0000_0000};
        vecs[5] = '{1'b0, 10'd100,  10'd10,   16'h0A0A, 1'b1, 32'h0000_32C8};
        vecs[6] = '{1'b1, 10'd1023, 10'd1023, 16'h7777, 1'b0, 32'h0000_0000};

        // Reset state
        @(negedge clk);
        check("rst_write", 64'(b_wr), 64'd0);
        check("rst_addr", 64'(b_addr), 64'd0);
        check("rst_data", 64'(b_data), 64'd0);
        check("rst_drop", 64'(b_drop), 64'd0);
        check("rst_busy", 64'(b_busy), 64'd0);
        check("rst_ready0", 64'(b_r0rdy), 64'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Table-driven single pixels and drops
        exp_drop = 0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            r0v = (vecs[i].sel == 1'b0);
            r1v = (vecs[i].sel == 1'b1);
            r0x = vecs[i].x; r0y = vecs[i].y; r0c = vecs[i].c;
            r1x = vecs[i].x; r1y = vecs[i].y; r1c = vecs[i].c;
            if (vecs[i].exp_wr) exp_q.push_back('{vecs[i].exp_addr, vecs[i].c});
            @(negedge clk);
            check("vec_ready_sel", 64'(vecs[i].sel ? b_r1rdy : b_r0rdy), 64'd1);
            check("vec_ready_other", 64'(vecs[i].sel ? b_r0rdy : b_r1rdy), 64'd0);
            @(posedge clk);
            #1;
            r0v = 1'b0; r1v = 1'b0;
            if (!vecs[i].exp_wr) exp_drop++;
            @(negedge clk);
            check("vec_write_next_cycle", 64'(b_wr), 64'(vecs[i].exp_wr));
            check("vec_drop_count", 64'(b_drop), 64'(exp_drop));
        end
        @(posedge clk);
        @(negedge clk);
        check("vec_idle_write", 64'(b_wr), 64'd0);
        check("vec_queue_empty", 64'(exp_q.size()), 64'd0);

        // Contention: alternating grants, back-to-back writes
        do_reset();
        pop0 = n_pop;
        @(posedge clk);
        #1;
        r0v = 1'b1; r0x = 10'd1; r0y = 10'd0; r0c = 16'h1111;
        r1v = 1'b1; r1x = 10'd2; r1y = 10'd0; r1c = 16'h2222;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp0 = ((k % 2) == 0);
            check("cont_ready0", 64'(b_r0rdy), 64'(exp0));
            check("cont_ready1", 64'(b_r1rdy), 64'(!exp0));
            if (exp0) exp_q.push_back('{32'd2, 16'h1111});
            else      exp_q.push_back('{32'd4, 16'h2222});
            @(posedge clk);
        end
        #1 r0v = 1'b0; r1v = 1'b0;
        @(negedge clk);
        #1 check("cont_write_count", 64'(n_pop - pop0), 64'd4);
        @(negedge clk);
        check("cont_write_low", 64'(b_wr), 64'd0);

        // Backpressure: 5 stalled cycles hold the write stable
        @(posedge clk);
        #1;
        r0v = 1'b1; r0x = 10'd5; r0y = 10'd5; r0c = 16'hABCD;
        exp_q.push_back('{32'h0000_190A, 16'hABCD});
        @(negedge clk);
        check("bp_ready0", 64'(b_r0rdy), 64'd1);
        @(posedge clk);
        #1;
        waitreq = 1'b1; r0x = 10'd6; r1v = 1'b1;
        pop0 = n_pop;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_write", 64'(b_wr), 64'd1);
            check("bp_addr", 64'(b_addr), 64'h190A);
            check("bp_data", 64'(b_data), 64'hABCD);
            check("bp_ready0", 64'(b_r0rdy), 64'd0);
            check("bp_ready1", 64'(b_r1rdy), 64'd0);
            @(posedge clk);
            #1;
        end
        waitreq = 1'b0; r0v = 1'b0; r1v = 1'b0;
        @(negedge clk);
        #1 check("bp_one_write", 64'(n_pop - pop0), 64'd1);
        @(negedge clk);
        check("bp_write_low", 64'(b_wr), 64'd0);
        check("bp_still_one", 64'(n_pop - pop0), 64'd1);

        // Out of range drops and saturation
        do_reset();
        @(posedge clk);
        #1 r1v = 1'b1; r1x = 10'd640; r1y = 10'd0;
        @(negedge clk);
        check("oor_ready_x", 64'(b_r1rdy), 64'd1);
        @(posedge clk);
        #1 r1x = 10'd0; r1y = 10'd480;
        @(negedge clk);
        check("oor_ready_y", 64'(b_r1rdy), 64'd1);
        check("oor_drop1", 64'(b_drop), 64'd1);
        @(posedge clk);
        #1 r1v = 1'b0;
        @(negedge clk);
        check("oor_drop2", 64'(b_drop), 64'd2);
        check("oor_no_write", 64'(b_wr), 64'd0);
        @(posedge clk);
        #1 r1v = 1'b1; r1x = 10'd1000; r1y = 10'd0;
        repeat (65533) @(posedge clk);
        @(negedge clk);
        check("sat_reach", 64'(b_drop), 64'hFFFF);
        repeat (4) @(posedge clk);
        #1 r1v = 1'b0;
        @(negedge clk);
        check("sat_hold", 64'(b_drop), 64'hFFFF);
        check("sat_no_write", 64'(b_wr), 64'd0);

        // Clear on the 4x2 instance behind a stalled pixel write
        do_reset();
        mon_sel = 2'd1;
        pop0 = n_pop;
        @(posedge clk);
        #1;
        waitreq = 1'b1;
        r0v = 1'b1; r0x = 10'd1; r0y = 10'd1; r0c = 16'h07E0;
        exp_q.push_back('{32'd10, 16'h07E0});
        @(negedge clk);
        check("clr_px_ready", 64'(s_r0rdy), 64'd1);
        check("clr_busy_before", 64'(s_busy), 64'd0);
        @(posedge clk);
        #1;
        r0v = 1'b0; clr_start = 1'b1; clr_color = 16'h001F;
        for (int n = 0; n < 8; n++) exp_q.push_back('{AW'(n * 2), 16'h001F});
        @(negedge clk);
        check("clr_busy_same_cycle", 64'(s_busy), 64'd0);
        check("clr_px_stalled", 64'(s_wr), 64'd1);
        @(posedge clk);
        #1;
        clr_start = 1'b0; clr_color = 16'h0000;
        r0v = 1'b1; r0x = 10'd0; r0y = 10'd0;
        r1v = 1'b1; r1x = 10'd1; r1y = 10'd0;
        @(negedge clk);
        check("clr_busy_next", 64'(s_busy), 64'd1);
        check("clr_block0", 64'(s_r0rdy), 64'd0);
        check("clr_block1", 64'(s_r1rdy), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("clr_px_held_addr", 64'(s_addr), 64'd10);
        check("clr_block0_stall", 64'(s_r0rdy), 64'd0);
        @(posedge clk);
        #1 waitreq = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            waitreq = ((c % 3) == 2);
            if (c == 4) begin
                clr_start = 1'b1; clr_color = 16'h3333;
            end else begin
                clr_start = 1'b0;
            end
            if (c >= 3) begin
                r0v = 1'b0; r1v = 1'b0;
            end
            @(negedge clk);
            #1;
            check("clr_busy_during", 64'(s_busy), 64'd1);
            check("clr_block_during", 64'({s_r0rdy, s_r1rdy}), 64'd0);
            if ((n_pop - pop0) >= 9) break;
        end
        check("clr_total_writes", 64'(n_pop - pop0), 64'd9);
        @(negedge clk);
        check("clr_done_write", 64'(s_wr), 64'd0);
        check("clr_done_busy", 64'(s_busy), 64'd0);
        repeat (3) @(negedge clk);
        check("clr_no_extra", 64'(n_pop - pop0), 64'd9);
        check("clr_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of a fill
        mon_sel = 2'd2;
        @(posedge clk);
        #1 clr_start = 1'b1; clr_color = 16'h0F0F;
        @(posedge clk);
        #1 clr_start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("mid_clr_write", 64'(s_wr), 64'd1);
        check("mid_clr_busy", 64'(s_busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check("arst_write", 64'(s_wr), 64'd0);
        check("arst_addr", 64'(s_addr), 64'd0);
        check("arst_data", 64'(s_data), 64'd0);
        check("arst_busy", 64'(s_busy), 64'd0);
        check("arst_drop", 64'(s_drop), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        r0v = 1'b1; r0x = 10'd0; r0y = 10'd0;
        r1v = 1'b1; r1x = 10'd1; r1y = 10'd0;
        @(negedge clk);
        check("post_rst_tie0", 64'(s_r0rdy), 64'd1);
        check("post_rst_tie1", 64'(s_r1rdy), 64'd0);
        @(posedge clk);
        #1 r0v = 1'b0; r1v = 1'b0;
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
